axi_bridge_mp: RTL and testbench

AXI_BRIDGE_MP -- requirements
Module: axi_bridge_mp

---
 rtl/axi_bridge_pkg.sv | 14 +
 rtl/rr_arbiter.sv | 26 ++
 rtl/axi_bridge_mp.sv | 269 ++++++++++++++++++++++++++
 tb/tb_axi_bridge_mp.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_bridge_pkg.sv
// Shared AXI3 constants and engine state encodings for the multi-port bridge.
package axi_bridge_pkg;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

  localparam logic [2:0] SIZE_1B = 3'd0;
  localparam logic [2:0] SIZE_2B = 3'd1;
  localparam logic [2:0] SIZE_4B = 3'd2;

  typedef enum logic [1:0] {R_IDLE, R_AR, R_DATA} rd_state_e;
  typedef enum logic [1:0] {W_IDLE, W_REQ, W_B}   wr_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after ptr_i.
module rr_arbiter #(
  parameter  int N  = 2,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  grant_o
);

  // Scan from the far end so the requester nearest the pointer is written last.
  always_comb begin
    grant_o = '0;
    for (int s = 0; s < N; s++) begin
      if (ptr_i == PW'(s)) begin
        for (int i = N - 1; i >= 0; i--) begin
          if (req_i[(s + i) % N]) begin
            grant_o              = '0;
            grant_o[(s + i) % N] = 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/axi_bridge_mp.sv
// Multi-port sram-like to AXI3 master bridge with independent read and write
// engines, round-robin port arbitration and a read-after-write address guard.
//
// state  | meaning
// R_IDLE | read engine free, arbitrating among read requesters
// R_AR   | AR channel presented, waiting for arready
// R_DATA | accepting read beats until rlast
// W_IDLE | write engine free, arbitrating among write requesters
// W_REQ  | AW and W presented, each retired on its own ready
// W_B    | waiting for the write response
module axi_bridge_mp
  import axi_bridge_pkg::*;
#(
  parameter int NPORT = 2,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NPORT-1:0]    req,
  input  logic [NPORT-1:0]    wr,
  input  logic [3*NPORT-1:0]  size,
  input  logic [4*NPORT-1:0]  len,
  input  logic [AW*NPORT-1:0] addr,
  input  logic [4*NPORT-1:0]  wstrb,
  input  logic [DW*NPORT-1:0] wdata,
  output logic [NPORT-1:0]    addr_ok,
  output logic [NPORT-1:0]    data_ok,
  output logic [NPORT-1:0]    last,
  output logic [DW-1:0]       rdata,
  output logic                bus_err,
  output logic [3:0]          m_arid,
  output logic [AW-1:0]       m_araddr,
  output logic [3:0]          m_arlen,
  output logic [2:0]          m_arsize,
  output logic [1:0]          m_arburst,
  output logic [1:0]          m_arlock,
  output logic [3:0]          m_arcache,
  output logic [2:0]          m_arprot,
  output logic                m_arvalid,
  input  logic                m_arready,
  input  logic [3:0]          m_rid,
  input  logic [DW-1:0]       m_rdata,
  input  logic [1:0]          m_rresp,
  input  logic                m_rlast,
  input  logic                m_rvalid,
  output logic                m_rready,
  output logic [3:0]          m_awid,
  output logic [AW-1:0]       m_awaddr,
  output logic [3:0]          m_awlen,
  output logic [2:0]          m_awsize,
  output logic [1:0]          m_awburst,
  output logic [1:0]          m_awlock,
  output logic [3:0]          m_awcache,
  output logic [2:0]          m_awprot,
  output logic                m_awvalid,
  input  logic                m_awready,
  output logic [3:0]          m_wid,
  output logic [DW-1:0]       m_wdata,
  output logic [3:0]          m_wstrb,
  output logic                m_wlast,
  output logic                m_wvalid,
  input  logic                m_wready,
  input  logic [3:0]          m_bid,
  input  logic [1:0]          m_bresp,
  input  logic                m_bvalid,
  output logic                m_bready
);

  localparam int PW = (NPORT > 1) ? $clog2(NPORT) : 1;

  rd_state_e         r_state_q;
  wr_state_e         w_state_q;
  logic [PW-1:0]     rd_ptr_q, wr_ptr_q, rd_ptr_d, wr_ptr_d;
  logic [PW-1:0]     r_port_q, w_port_q, rd_idx, wr_idx;
  logic [AW-1:0]     r_addr_q, w_addr_q, rd_addr_sel, wr_addr_sel;
  logic [3:0]        r_len_q, rd_len_sel;
  logic [2:0]        r_size_q, w_size_q, rd_size_sel, wr_size_sel;
  logic [3:0]        w_strb_q, wr_strb_sel;
  logic [DW-1:0]     w_data_q, wr_data_sel;
  logic              arvalid_q, rready_q, awvalid_q, wvalid_q, bready_q, bus_err_q;
  logic [NPORT-1:0]  raw_hit, rd_cand, wr_cand, rd_gnt, wr_gnt;
  logic              rd_take, wr_take, rd_beat, b_done, aw_left, w_left;
  logic              unused_ok;

  assign unused_ok = ^{m_rid, m_bid};

  // A read whose word address matches the in-flight write is held back.
  always_comb begin
    raw_hit = '0;
    rd_cand = '0;
    wr_cand = '0;
    for (int p = 0; p < NPORT; p++) begin
      raw_hit[p] = (w_state_q != W_IDLE) && (addr[p*AW+2 +: AW-2] == w_addr_q[AW-1:2]);
      rd_cand[p] = req[p] && !wr[p] && !raw_hit[p];
      wr_cand[p] = req[p] && wr[p];
    end
  end

  rr_arbiter #(.N(NPORT)) u_rd_arb (.req_i(rd_cand), .ptr_i(rd_ptr_q), .grant_o(rd_gnt));
  rr_arbiter #(.N(NPORT)) u_wr_arb (.req_i(wr_cand), .ptr_i(wr_ptr_q), .grant_o(wr_gnt));

  assign rd_take = !reset && (r_state_q == R_IDLE) && (|rd_gnt);
  assign wr_take = !reset && (w_state_q == W_IDLE) && (|wr_gnt);

  always_comb begin
    rd_idx      = '0;
    wr_idx      = '0;
    rd_addr_sel = '0;
    rd_len_sel  = '0;
    rd_size_sel = '0;
    wr_addr_sel = '0;
    wr_size_sel = '0;
    wr_strb_sel = '0;
    wr_data_sel = '0;
    for (int p = 0; p < NPORT; p++) begin
      if (rd_gnt[p]) begin
        rd_idx      = PW'(p);
        rd_addr_sel = addr[p*AW +: AW];
        rd_len_sel  = len[p*4 +: 4];
        rd_size_sel = size[p*3 +: 3];
      end
      if (wr_gnt[p]) begin
        wr_idx      = PW'(p);
        wr_addr_sel = addr[p*AW +: AW];
        wr_size_sel = size[p*3 +: 3];
        wr_strb_sel = wstrb[p*4 +: 4];
        wr_data_sel = wdata[p*DW +: DW];
      end
    end
  end

  assign rd_ptr_d = (rd_idx == PW'(NPORT - 1)) ? '0 : rd_idx + 1'b1;
  assign wr_ptr_d = (wr_idx == PW'(NPORT - 1)) ? '0 : wr_idx + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state_q <= R_IDLE;
      rd_ptr_q  <= '0;
      r_port_q  <= '0;
      r_addr_q  <= '0;
      r_len_q   <= '0;
      r_size_q  <= '0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
    end else begin
      case (r_state_q)
        R_IDLE: if (rd_take) begin
          r_state_q <= R_AR;
          arvalid_q <= 1'b1;
          rd_ptr_q  <= rd_ptr_d;
          r_port_q  <= rd_idx;
          r_addr_q  <= rd_addr_sel;
          r_len_q   <= rd_len_sel;
          r_size_q  <= rd_size_sel;
        end
        R_AR: if (m_arready) begin
          r_state_q <= R_DATA;
          arvalid_q <= 1'b0;
          rready_q  <= 1'b1;
        end
        R_DATA: if (m_rvalid && m_rlast) begin
          r_state_q <= R_IDLE;
          rready_q  <= 1'b0;
        end
        default: r_state_q <= R_IDLE;
      endcase
    end
  end

  assign aw_left = awvalid_q && !m_awready;
  assign w_left  = wvalid_q && !m_wready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w_state_q <= W_IDLE;
      wr_ptr_q  <= '0;
      w_port_q  <= '0;
      w_addr_q  <= '0;
      w_size_q  <= '0;
      w_strb_q  <= '0;
      w_data_q  <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
    end else begin
      case (w_state_q)
        W_IDLE: if (wr_take) begin
          w_state_q <= W_REQ;
          awvalid_q <= 1'b1;
          wvalid_q  <= 1'b1;
          wr_ptr_q  <= wr_ptr_d;
          w_port_q  <= wr_idx;
          w_addr_q  <= wr_addr_sel;
          w_size_q  <= wr_size_sel;
          w_strb_q  <= wr_strb_sel;
          w_data_q  <= wr_data_sel;
        end
        W_REQ: begin
          awvalid_q <= aw_left;
          wvalid_q  <= w_left;
          if (!aw_left && !w_left) begin
            w_state_q <= W_B;
            bready_q  <= 1'b1;
          end
        end
        W_B: if (m_bvalid) begin
          w_state_q <= W_IDLE;
          bready_q  <= 1'b0;
        end
        default: w_state_q <= W_IDLE;
      endcase
    end
  end

  assign rd_beat = rready_q && m_rvalid;
  assign b_done  = bready_q && m_bvalid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus_err_q <= 1'b0;
    end else if ((rd_beat && m_rresp != RESP_OKAY) || (b_done && m_bresp != RESP_OKAY)) begin
      bus_err_q <= 1'b1;
    end
  end

  always_comb begin
    addr_ok = '0;
    data_ok = '0;
    last    = '0;
    if (rd_take) addr_ok = addr_ok | rd_gnt;
    if (wr_take) addr_ok = addr_ok | wr_gnt;
    for (int p = 0; p < NPORT; p++) begin
      data_ok[p] = (rd_beat && r_port_q == PW'(p)) || (b_done && w_port_q == PW'(p));
      last[p]    = (rd_beat && m_rlast && r_port_q == PW'(p)) || (b_done && w_port_q == PW'(p));
    end
  end

  assign rdata   = m_rdata;
  assign bus_err = bus_err_q;

  assign m_arid    = 4'(r_port_q);
  assign m_araddr  = r_addr_q;
  assign m_arlen   = r_len_q;
  assign m_arsize  = r_size_q;
  assign m_arburst = BURST_INCR;
  assign m_arlock  = 2'b00;
  assign m_arcache = 4'b0000;
  assign m_arprot  = 3'b000;
  assign m_arvalid = arvalid_q;
  assign m_rready  = rready_q;

  assign m_awid    = 4'(w_port_q);
  assign m_awaddr  = w_addr_q;
  assign m_awlen   = 4'd0;
  assign m_awsize  = w_size_q;
  assign m_awburst = BURST_INCR;
  assign m_awlock  = 2'b00;
  assign m_awcache = 4'b0000;
  assign m_awprot  = 3'b000;
  assign m_awvalid = awvalid_q;
  assign m_wid     = 4'(w_port_q);
  assign m_wdata   = w_data_q;
  assign m_wstrb   = w_strb_q;
  assign m_wlast   = 1'b1;
  assign m_wvalid  = wvalid_q;
  assign m_bready  = bready_q;

endmodule

// File: tb/tb_axi_bridge_mp.sv
// Directed bench for axi_bridge_mp: two ports, hand-driven AXI slave responses.
module tb_axi_bridge_mp;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req, wr;
  logic [5:0]  size;
  logic [7:0]  len;
  logic [63:0] addr;
  logic [7:0]  wstrb;
  logic [63:0] wdata;
  logic [1:0]  addr_ok, data_ok, last;
  logic [31:0] rdata;
  logic        bus_err;
  logic [3:0]  m_arid, m_arlen, m_arcache, m_awid, m_awlen, m_awcache, m_wid, m_wstrb;
  logic [31:0] m_araddr, m_awaddr, m_wdata, m_rdata;
  logic [2:0]  m_arsize, m_arprot, m_awsize, m_awprot;
  logic [1:0]  m_arburst, m_arlock, m_awburst, m_awlock, m_rresp, m_bresp;
  logic        m_arvalid, m_arready, m_rlast, m_rvalid, m_rready;
  logic        m_awvalid, m_awready, m_wlast, m_wvalid, m_wready, m_bvalid, m_bready;
  logic [3:0]  m_rid, m_bid;

  logic [31:0] pa[2];
  logic [31:0] pd[2];
  logic [3:0]  pl[2];

  int n_chk  = 0;
  int n_pass = 0;
  int aw_hs  = 0;
  int w_hs   = 0;
  int aw0, w0;

  assign addr  = {pa[1], pa[0]};
  assign wdata = {pd[1], pd[0]};
  assign len   = {pl[1], pl[0]};
  assign size  = 6'b010_010;
  assign wstrb = 8'hFF;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!reset && m_awvalid && m_awready) aw_hs++;
    if (!reset && m_wvalid && m_wready) w_hs++;
  end

  axi_bridge_mp #(.NPORT(2), .AW(32), .DW(32)) dut (
    .clk(clk), .reset(reset),
    .req(req), .wr(wr), .size(size), .len(len), .addr(addr), .wstrb(wstrb), .wdata(wdata),
    .addr_ok(addr_ok), .data_ok(data_ok), .last(last), .rdata(rdata), .bus_err(bus_err),
    .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
    .m_arburst(m_arburst), .m_arlock(m_arlock), .m_arcache(m_arcache), .m_arprot(m_arprot),
    .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rid(m_rid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
    .m_rvalid(m_rvalid), .m_rready(m_rready),
    .m_awid(m_awid), .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize),
    .m_awburst(m_awburst), .m_awlock(m_awlock), .m_awcache(m_awcache), .m_awprot(m_awprot),
    .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wid(m_wid), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast),
    .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bid(m_bid), .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_port(input bit p, input logic r, input logic w, input logic [31:0] a,
                          input logic [3:0] l, input logic [31:0] d);
    req[p] = r;
    wr[p]  = w;
    pa[p]  = a;
    pl[p]  = l;
    pd[p]  = d;
  endtask

  initial begin
    reset = 1'b1;
    req = '0; wr = '0;
    pa[0] = '0; pa[1] = '0; pd[0] = '0; pd[1] = '0; pl[0] = '0; pl[1] = '0;
    m_arready = 0; m_rvalid = 0; m_rlast = 0; m_rdata = '0; m_rresp = 2'b00; m_rid = '0;
    m_awready = 0; m_wready = 0; m_bvalid = 0; m_bresp = 2'b00; m_bid = '0;
    tick(); tick(); tick();

    // reset state, with a request held during reset
    set_port(0, 1, 0, 32'h1FC00000, 4'd3, 0);
    #1;
    chk("rst_addr_ok", addr_ok, 2'b00);
    chk("rst_outputs", {m_arvalid, m_awvalid, m_wvalid, m_rready, m_bready, data_ok, last, bus_err}, 0);
    req = '0;
    tick();
    reset = 1'b0;

    // port0 4-beat read, arready two cycles late
    tick();
    set_port(0, 1, 0, 32'h1FC00000, 4'd3, 0);
    #1;
    chk("t1_addr_ok", addr_ok, 2'b01);
    tick();
    req[0] = 0;
    #1;
    chk("t1_arvalid", m_arvalid, 1);
    chk("t1_arlen", m_arlen, 3);
    chk("t1_arid", m_arid, 0);
    chk("t1_araddr", m_araddr, 32'h1FC00000);
    chk("t1_arburst_size", {m_arburst, m_arsize}, {2'b01, 3'd2});
    tick();
    #1;
    chk("t1_ar_hold", m_arvalid, 1);
    tick();
    m_arready = 1;
    tick();
    m_arready = 0;
    #1;
    chk("t1_ar_to_r", {m_arvalid, m_rready}, 2'b01);
    for (int b = 0; b < 4; b++) begin
      m_rvalid = 1;
      m_rdata  = 32'hA0 + b;
      m_rlast  = (b == 3);
      #1;
      chk("t1_data_ok", data_ok, 2'b01);
      chk("t1_last", last, (b == 3) ? 2'b01 : 2'b00);
      chk("t1_rdata", rdata, 32'hA0 + b);
      tick();
    end
    m_rvalid = 0; m_rlast = 0;
    #1;
    chk("t1_rready_off", m_rready, 0);

    // two ports reading continuously: grants alternate from a fresh pointer
    reset = 1'b1; #1; reset = 1'b0;
    tick();
    set_port(0, 1, 0, 32'h2000, 4'd0, 0);
    set_port(1, 1, 0, 32'h3000, 4'd0, 0);
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("t2_grant", addr_ok, (k % 2) ? 2'b10 : 2'b01);
      tick();
      #1;
      chk("t2_arid", m_arid, k % 2);
      chk("t2_araddr", m_araddr, (k % 2) ? 32'h3000 : 32'h2000);
      m_arready = 1;
      tick();
      m_arready = 0;
      m_rvalid = 1; m_rlast = 1; m_rdata = k;
      #1;
      chk("t2_data_ok", data_ok, (k % 2) ? 2'b10 : 2'b01);
      tick();
      m_rvalid = 0; m_rlast = 0;
    end
    req = '0;

    // port1 write to 0x100 holds off port0 read of 0x100 until B
    set_port(1, 1, 1, 32'h100, 4'd0, 32'hDEADBEEF);
    #1;
    chk("t3_w_addr_ok", addr_ok, 2'b10);
    tick();
    req[1] = 0;
    set_port(0, 1, 0, 32'h100, 4'd0, 0);
    #1;
    chk("t3_aw_w_valid", {m_awvalid, m_wvalid}, 2'b11);
    chk("t3_awaddr", m_awaddr, 32'h100);
    chk("t3_ids", {m_awid, m_wid}, 8'h11);
    chk("t3_wdata", m_wdata, 32'hDEADBEEF);
    chk("t3_wlast_awlen_strb", {m_wlast, m_awlen, m_wstrb}, {1'b1, 4'd0, 4'hF});
    chk("t3_raw_hold", addr_ok, 2'b00);
    tick();
    #1;
    chk("t3_raw_hold2", {addr_ok, m_arvalid}, 3'b000);
    m_awready = 1; m_wready = 1;
    tick();
    m_awready = 0; m_wready = 0;
    #1;
    chk("t3_to_b", {m_awvalid, m_wvalid, m_bready}, 3'b001);
    chk("t3_raw_hold3", addr_ok, 2'b00);
    m_bvalid = 1; m_bresp = 2'b00;
    #1;
    chk("t3_b_ok_last", {data_ok, last}, 4'b1010);
    chk("t3_raw_hold4", addr_ok, 2'b00);
    tick();
    m_bvalid = 0;
    #1;
    chk("t3_read_grant", addr_ok, 2'b01);
    tick();
    req[0] = 0;
    #1;
    chk("t3_arvalid", m_arvalid, 1);
    chk("t3_araddr", m_araddr, 32'h100);
    m_arready = 1;
    tick();
    m_arready = 0; m_rvalid = 1; m_rlast = 1; m_rdata = 32'h55;
    #1;
    chk("t3_read_data_ok", data_ok, 2'b01);
    tick();
    m_rvalid = 0; m_rlast = 0;

    // wready three cycles ahead of awready
    aw0 = aw_hs; w0 = w_hs;
    set_port(1, 1, 1, 32'h200, 4'd0, 32'h12345678);
    #1;
    chk("t4_addr_ok", addr_ok, 2'b10);
    tick();
    req[1] = 0;
    m_wready = 1;
    tick();
    m_wready = 0;
    #1;
    chk("t4_w_done_aw_pend", {m_awvalid, m_wvalid}, 2'b10);
    tick();
    tick();
    m_awready = 1;
    tick();
    m_awready = 0;
    #1;
    chk("t4_to_b", {m_awvalid, m_wvalid, m_bready}, 3'b001);
    chk("t4_w_beats", w_hs - w0, 1);
    chk("t4_aw_beats", aw_hs - aw0, 1);
    chk("t4_no_early_ok", data_ok, 2'b00);
    tick();
    m_bvalid = 1;
    #1;
    chk("t4_data_ok", data_ok, 2'b10);
    tick();
    m_bvalid = 0;

    // reset during beat 2 of a 4-beat read
    set_port(0, 1, 0, 32'h400, 4'd3, 0);
    #1;
    chk("t5_addr_ok", addr_ok, 2'b01);
    tick();
    req[0] = 0;
    m_arready = 1;
    tick();
    m_arready = 0;
    m_rvalid = 1; m_rdata = 32'h1;
    #1;
    chk("t5_beat1", data_ok, 2'b01);
    tick();
    m_rdata = 32'h2;
    reset = 1'b1;
    #1;
    chk("t5_reset_kill", {m_rready, m_arvalid, data_ok, last}, 0);
    reset = 1'b0;
    m_rvalid = 0;
    tick();
    set_port(0, 1, 0, 32'h500, 4'd0, 0);
    #1;
    chk("t5_idle_grant", addr_ok, 2'b01);
    tick();
    req[0] = 0;
    #1;
    chk("t5_new_ar", {m_arvalid, m_araddr}, {1'b1, 32'h500});
    m_arready = 1;
    tick();
    m_arready = 0; m_rvalid = 1; m_rlast = 1; m_rdata = 32'h77;
    #1;
    chk("t5_new_data", {data_ok, last, rdata}, {2'b01, 2'b01, 32'h77});
    tick();
    m_rvalid = 0; m_rlast = 0;

    // SLVERR on B: still completes, bus_err sticks until reset
    #1;
    chk("t6_err_clear", bus_err, 0);
    set_port(0, 1, 1, 32'h600, 4'd0, 32'hCAFE);
    #1;
    chk("t6_addr_ok", addr_ok, 2'b01);
    tick();
    req[0] = 0;
    m_awready = 1; m_wready = 1;
    tick();
    m_awready = 0; m_wready = 0;
    m_bvalid = 1; m_bresp = 2'b10;
    #1;
    chk("t6_data_ok", {data_ok, last}, 4'b0101);
    tick();
    m_bvalid = 0; m_bresp = 2'b00;
    #1;
    chk("t6_err_set", bus_err, 1);
    tick(); tick();
    #1;
    chk("t6_err_sticky", bus_err, 1);
    reset = 1'b1;
    #1;
    chk("t6_err_reset", bus_err, 0);
    reset = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
